// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types, defaults and saturating helpers for the lock output stage
package lock_pkg;

  // Default sample width of the lock loop datapath
  localparam int DW_DEF = 14;

  // Output stage operating state; encoding is exposed on state_o
  typedef enum logic [1:0] {
    ST_SCAN  = 2'd0,
    ST_CATCH = 2'd1,
    ST_LOCK  = 2'd2
  } lock_state_e;

  // Clamp a signed value into [lo, hi]
  function automatic int sat_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Clamp a signed value into the symmetric window [-lim, lim]
  function automatic int sat_sym(input int v, input int lim);
    return sat_clamp(v, -lim, lim);
  endfunction

endpackage

// File: rtl/lock_relock_ctrl_if.sv
// rtl/lock_relock_ctrl_if.sv - handshake between the lock output stage and the upstream PID block
interface lock_relock_ctrl_if
  import lock_pkg::*;
#(
  parameter int DW = DW_DEF
);

  // PID output sample feeding the output stage
  logic signed [DW-1:0] pid_i;
  // Hold request for the PID output while it is not driving the actuator
  logic                 pid_freeze_o;
  // Single-cycle integrator load strobe and the value to load
  logic                 pid_int_rst_o;
  logic signed [DW-1:0] int_rst_val_o;

  // Output stage side
  modport master (
    input  pid_i,
    output pid_freeze_o,
    output pid_int_rst_o,
    output int_rst_val_o
  );

  // PID side
  modport slave (
    output pid_i,
    input  pid_freeze_o,
    input  pid_int_rst_o,
    input  int_rst_val_o
  );

endinterface

// File: rtl/lock_slew_lim.sv
// rtl/lock_slew_lim.sv - combinational slew limiter stepping a value toward a target
module lock_slew_lim
  import lock_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic signed [DW-1:0] target,
  input  logic signed [DW-1:0] current,
  input  logic        [DW-1:0] slew,
  output logic signed [DW-1:0] next_val
);

  // One extra bit keeps the difference of two full-scale samples exact
  logic signed [DW:0] delta;
  int                 lim;
  int                 step;

  assign delta = (DW+1)'(target) - (DW+1)'(current);
  assign lim   = int'({1'b0, slew});
  assign step  = sat_sym(int'(delta), lim);

  // A zero slew limit means the target is passed straight through
  always_comb begin
    next_val = target;
    if (slew != '0) begin
      next_val = DW'(int'(current) + step);
    end
  end

endmodule

// File: rtl/lock_relock_ctrl.sv
// rtl/lock_relock_ctrl.sv - scan ramp, lock capture and PID hand-over for the actuator DAC (option: LOCK_AUTO_RELOCK_EN)
module lock_relock_ctrl
  import lock_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int HW = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  lock_relock_ctrl_if.master   pid_if,
  input  logic signed [DW-1:0] mon_i,
  input  logic                 lock_req_i,
  input  logic signed [DW-1:0] thr_i,
  input  logic signed [DW-1:0] ramp_lo_i,
  input  logic signed [DW-1:0] ramp_hi_i,
  input  logic        [DW-1:0] ramp_step_i,
  input  logic        [DW-1:0] slew_i,
  input  logic        [HW-1:0] hold_cyc_i,
  output logic signed [DW-1:0] dat_o,
  output logic        [1:0]    state_o,
  output logic                 locked_o
);

  // Ramp accumulator is one bit wider than the samples
  localparam int RW = DW + 1;

`ifdef LOCK_AUTO_RELOCK_EN
  localparam bit AUTO_RELOCK = 1'b1;
`else
  localparam bit AUTO_RELOCK = 1'b0;
`endif

  lock_state_e          state_q, state_d;
  logic signed [RW-1:0] ramp_q, ramp_d;
  logic                 dir_up_q, dir_up_d;
  logic [HW-1:0]        hold_q, hold_d;

  logic                 mon_ok;
  logic                 capture;
  logic                 loss;

  // Wide copies so that ramp + step never overflows before the limit test
  logic signed [RW+1:0] r_w, lo_w, hi_w, up_w, dn_w;

  logic signed [DW-1:0] slew_nx;
  logic signed [DW-1:0] dat_d;
  logic signed [DW-1:0] seed_d;
  logic                 freeze_d;
  logic                 int_rst_d;
  logic                 locked_d;

  assign mon_ok  = (mon_i >= thr_i);
  assign capture = lock_req_i && mon_ok;

  assign r_w  = (RW+2)'(ramp_q);
  assign lo_w = (RW+2)'(ramp_lo_i);
  assign hi_w = (RW+2)'(ramp_hi_i);
  assign up_w = r_w + $signed({3'b000, ramp_step_i});
  assign dn_w = r_w - $signed({3'b000, ramp_step_i});

  lock_slew_lim #(
    .DW(DW)
  ) u_slew (
    .target  (pid_if.pid_i),
    .current (dat_o),
    .slew    (slew_i),
    .next_val(slew_nx)
  );

  // Loss counter: counts consecutive low-monitor cycles and sticks at all-ones
  always_comb begin
    hold_d = hold_q;
    if (mon_ok) begin
      hold_d = '0;
    end else if (hold_q != '1) begin
      hold_d = hold_q + 1'b1;
    end
  end

  // Loss fires on the cycle that brings the count up to the programmed hold
  assign loss = (hold_cyc_i != '0) && !mon_ok && (hold_d >= hold_cyc_i);

  // State register
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      state_q <= ST_SCAN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a lock request drop outranks loss, which outranks capture
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SCAN: begin
        if (capture) state_d = ST_CATCH;
      end
      ST_CATCH: begin
        state_d = lock_req_i ? ST_LOCK : ST_SCAN;
      end
      ST_LOCK: begin
        if (!lock_req_i) begin
          state_d = ST_SCAN;
        end else if (AUTO_RELOCK && loss) begin
          state_d = ST_SCAN;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  // Next output values, registered below so every output is a flop
  always_comb begin
    dat_d     = dat_o;
    seed_d    = pid_if.int_rst_val_o;
    freeze_d  = (state_d != ST_LOCK);
    int_rst_d = (state_d == ST_CATCH);
    locked_d  = (state_d == ST_LOCK);
    if (state_q == ST_SCAN) begin
      dat_d = DW'(ramp_q);
    end else if (state_q == ST_LOCK && state_d == ST_LOCK) begin
      dat_d = slew_nx;
    end
    if (state_q == ST_SCAN && state_d == ST_CATCH) begin
      seed_d = DW'(ramp_q);
    end
  end

  // Ramp: triangular sweep between the limits, frozen outside SCAN
  always_comb begin
    ramp_d   = ramp_q;
    dir_up_d = dir_up_q;
    if (state_q == ST_LOCK && state_d == ST_SCAN) begin
      ramp_d = RW'(dat_o);
    end else if (state_q == ST_SCAN && state_d == ST_SCAN) begin
      if (lo_w >= hi_w) begin
        ramp_d = RW'(ramp_lo_i);
      end else if (r_w > hi_w) begin
        ramp_d   = RW'(ramp_hi_i);
        dir_up_d = 1'b0;
      end else if (r_w < lo_w) begin
        ramp_d   = RW'(ramp_lo_i);
        dir_up_d = 1'b1;
      end else if (ramp_step_i != '0) begin
        if (dir_up_q) begin
          if (up_w >= hi_w) begin
            ramp_d   = RW'(ramp_hi_i);
            dir_up_d = 1'b0;
          end else begin
            ramp_d = RW'(up_w);
          end
        end else begin
          if (dn_w <= lo_w) begin
            ramp_d   = RW'(ramp_lo_i);
            dir_up_d = 1'b1;
          end else begin
            ramp_d = RW'(dn_w);
          end
        end
      end
    end
  end

  // Ramp accumulator, sweep direction and loss counter
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      ramp_q   <= '0;
      dir_up_q <= 1'b1;
      hold_q   <= '0;
    end else begin
      ramp_q   <= ramp_d;
      dir_up_q <= dir_up_d;
      hold_q   <= hold_d;
    end
  end

  // Output registers
  always_ff @(posedge clk_i) begin
    if (rstn_i) begin
      dat_o                <= '0;
      pid_if.pid_freeze_o  <= 1'b1;
      pid_if.pid_int_rst_o <= 1'b0;
      pid_if.int_rst_val_o <= '0;
      locked_o             <= 1'b0;
    end else begin
      dat_o                <= dat_d;
      pid_if.pid_freeze_o  <= freeze_d;
      pid_if.pid_int_rst_o <= int_rst_d;
      pid_if.int_rst_val_o <= seed_d;
      locked_o             <= locked_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_lock_relock_ctrl.sv
// tb/tb_lock_relock_ctrl.sv - directed vector bench for lock_relock_ctrl (follows LOCK_AUTO_RELOCK_EN)
module tb_lock_relock_ctrl;

  localparam int DW = 14;
  localparam int HW = 16;

`ifdef LOCK_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct {
    logic rst;
    logic req;
    int   mon;
    int   pid;
    int   slew;
    int   dat;
    int   st;
    int   frz;
    int   irst;
    int   seed;
    int   lk;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic signed [DW-1:0] mon, thr, lo, hi;
  logic        [DW-1:0] step, slew;
  logic        [HW-1:0] hold;
  logic signed [DW-1:0] dat;
  logic        [1:0]    st;
  logic                 lk;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[$];

  lock_relock_ctrl_if #(.DW(DW)) pid_if ();

  lock_relock_ctrl #(.DW(DW), .HW(HW)) dut (
    .clk_i      (clk),
    .rstn_i     (rst),
    .pid_if     (pid_if),
    .mon_i      (mon),
    .lock_req_i (req),
    .thr_i      (thr),
    .ramp_lo_i  (lo),
    .ramp_hi_i  (hi),
    .ramp_step_i(step),
    .slew_i     (slew),
    .hold_cyc_i (hold),
    .dat_o      (dat),
    .state_o    (st),
    .locked_o   (lk)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic q, input int m, input int p, input int s,
                     input int d, input int sv, input int f, input int ir, input int sd, input int l);
    vec_t v;
    v.rst = r; v.req = q; v.mon = m; v.pid = p; v.slew = s;
    v.dat = d; v.st = sv; v.frz = f; v.irst = ir; v.seed = sd; v.lk = l;
    vt.push_back(v);
  endtask

  task automatic apply(input logic r, input logic q, input int m, input int p, input int s);
    rst = r;
    req = q;
    mon = DW'(m);
    pid_if.pid_i = DW'(p);
    slew = DW'(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int d, input int sv, input int f,
                           input int ir, input int sd, input int l);
    chk({tag, " dat_o"}, int'(dat), d);
    chk({tag, " state_o"}, int'(st), sv);
    chk({tag, " pid_freeze_o"}, int'(pid_if.pid_freeze_o), f);
    chk({tag, " pid_int_rst_o"}, int'(pid_if.pid_int_rst_o), ir);
    chk({tag, " int_rst_val_o"}, int'(pid_if.int_rst_val_o), sd);
    chk({tag, " locked_o"}, int'(lk), l);
  endtask

  task automatic set_cfg(input int l, input int h, input int s, input int hc);
    lo   = DW'(l);
    hi   = DW'(h);
    step = DW'(s);
    hold = HW'(hc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ramp_exp[13] = '{0, 30, 60, 90, 100, 70, 40, 10, -20, -50, -80, -100, -70};

    thr = DW'(500);
    set_cfg(-100, 100, 30, 4);
    apply(1'b1, 1'b0, 0, 0, 0);

    // scan ramp from reset, lock request low
    add(1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 13; i++) add(0, 0, 0, 0, 0, ramp_exp[i], 0, 1, 0, 0, 0);
    // capture at r=60, then slew and hand-back to scan
    add(1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0,  30, 0, 1, 0, 0, 0);
    add(0, 1, 600, 60, 0,  60, 1, 1, 1, 60, 0);
    add(0, 1, 600, 60, 0,  60, 2, 0, 0, 60, 1);
    add(0, 1, 600, 0, 0,    0, 2, 0, 0, 60, 1);
    add(0, 1, 600, 35, 10, 10, 2, 0, 0, 60, 1);
    add(0, 1, 600, 35, 10, 20, 2, 0, 0, 60, 1);
    add(0, 1, 600, 35, 10, 30, 2, 0, 0, 60, 1);
    add(0, 1, 600, 35, 10, 35, 2, 0, 0, 60, 1);
    add(0, 1, 600, 35, 10, 35, 2, 0, 0, 60, 1);
    add(0, 1, 600, -35, 0, -35, 2, 0, 0, 60, 1);
    add(0, 0, 600, -35, 0, -35, 0, 1, 0, 60, 0);
    add(0, 0, 600, 0, 0,  -35, 0, 1, 0, 60, 0);
    add(0, 0, 600, 0, 0,   -5, 0, 1, 0, 60, 0);
    add(0, 0, 600, 0, 0,   25, 0, 1, 0, 60, 0);

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].req, vt[i].mon, vt[i].pid, vt[i].slew);
      tick();
      check_all($sformatf("vec%0d", i), vt[i].dat, vt[i].st, vt[i].frz,
                vt[i].irst, vt[i].seed, vt[i].lk);
    end

    // loss of lock held for 4 cycles
    set_cfg(-100, 100, 30, 4);
    apply(1, 0, 0, 0, 0);   tick();
    apply(0, 1, 600, 0, 0); tick();
    check_all("relock catch", 0, 1, 1, 1, 0, 0);
    apply(0, 1, 600, 20, 0); tick();
    apply(0, 1, 600, 20, 0); tick();
    check_all("relock lock", 20, 2, 0, 0, 0, 1);
    apply(0, 1, 0, 20, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("relock low%0d", i), 20, 2, 0, 0, 0, 1);
    end
    tick();
    check_all("relock low4", 20, AUTO ? 0 : 2, AUTO ? 1 : 0, 0, 0, AUTO ? 0 : 1);
    tick();
    chk("relock resume dat_o", int'(dat), 20);
    tick();
    chk("relock ramp dat_o", int'(dat), AUTO ? 50 : 20);
    apply(0, 1, 600, 20, 0); tick();
    check_all("relock rearm", AUTO ? 80 : 20, AUTO ? 1 : 2, AUTO ? 1 : 0,
              AUTO ? 1 : 0, AUTO ? 80 : 0, AUTO ? 0 : 1);

    // lock request drop coincides with loss
    set_cfg(-100, 100, 30, 2);
    apply(1, 0, 0, 0, 0);   tick();
    apply(0, 1, 600, 0, 0); tick(); tick();
    apply(0, 1, 0, 0, 0);   tick();
    chk("drop+loss pre state_o", int'(st), 2);
    apply(0, 0, 0, 0, 0);   tick();
    check_all("drop+loss", 0, 0, 1, 0, 0, 0);
    tick();
    check_all("drop+loss after", 0, 0, 1, 0, 0, 0);

    // degenerate window lo = hi
    set_cfg(50, 50, 30, 4);
    apply(1, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0); tick();
    chk("lo=hi first dat_o", int'(dat), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("lo=hi dat_o %0d", i), int'(dat), 50);
    end

    // reset while in CATCH
    set_cfg(-100, 100, 30, 4);
    apply(1, 0, 0, 0, 0);   tick();
    apply(0, 0, 0, 0, 0);   tick();
    apply(0, 1, 600, 0, 0); tick();
    check_all("catch before rst", 30, 1, 1, 1, 30, 0);
    apply(1, 1, 600, 0, 0); tick();
    check_all("rst in catch", 0, 0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
